// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Multicycle MIPS control FSM. Sequences the PC, instruction/data memory,
//   register file, ALU and PC mux one state per cycle. Decodes opcode/funct,
//   stalls on a req/ready memory handshake and gives up on a stuck memory
//   after TIMEOUT wait cycles.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   opcode      instr[31:26], held by the IR from DECODE onward
//   funct       instr[5:0]
//   zero        ALU zero flag (used by beq)
//   mem_ready   memory completes the current access this cycle
//   mem_req     memory access active, held until mem_ready
//   mem_we      write access (sw); implies mem_req
//   iord        memory address select: 0 = PC, 1 = ALUOut
//   ir_write    load instruction register
//   pc_en       PC load enable = pc_write | (pc_write_cond & zero)
//   pc_src      00 ALU result, 01 ALUOut (branch target), 10 jump target
//   alu_src_a   0 = PC, 1 = reg A
//   alu_src_b   00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   alu_op      0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt
//   reg_write   register file write enable
//   reg_dst     write register select: 0 = rt, 1 = rd
//   mem_to_reg  write data select: 0 = ALUOut, 1 = memory data register
//   illegal     1-cycle pulse on unknown opcode (DECODE) or funct (EXEC)
//   bus_err     1-cycle pulse when a memory wait times out
//   state       current state encoding (debug)
//   cycle_cnt   (MIPS_CTRL_PERF_EN) clocks spent outside IDLE
//   instr_cnt   (MIPS_CTRL_PERF_EN) instructions retired
//
// Configuration macro
//   MIPS_CTRL_PERF_EN  adds the cycle_cnt / instr_cnt performance counters.
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [OP_W-1:0]  alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             bus_err,
  output logic [3:0]       state
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  // Moore part of the control word; registered alongside the state so the
  // outputs come straight from flops.
  typedef struct packed {
    logic            mem_req;
    logic            mem_we;
    logic            iord;
    logic            ir_write;
    logic            pc_write;
    logic            pc_write_cond;
    logic [1:0]      pc_src;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [OP_W-1:0] alu_op;
    logic            reg_write;
    logic            reg_dst;
    logic            mem_to_reg;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [OP_W-1:0] ALU_AND = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] ALU_OR  = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] ALU_ADD = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] ALU_SUB = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] ALU_SLT = OP_W'(4'b0111);

  // The wait counter only has to reach TIMEOUT-1; at that value a further
  // not-ready cycle is the timeout cycle itself.
  localparam int              WC_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WC_W-1:0] TO_LAST = WC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // The ALU op encodings need at least 3 bits to stay distinct.
  if (OP_W < 3 || CNT_W < 1) begin : g_bad_params
    $error("mips_multicycle_ctrl: OP_W must be >= 3 and CNT_W >= 1");
  end

  // R-type funct decode: {legal, alu_op}
  function automatic logic [OP_W:0] funct_decode(input logic [5:0] fn);
    logic [OP_W:0] r;
    r = '0;
    case (fn)
      FN_ADD:  r = {1'b1, ALU_ADD};
      FN_SUB:  r = {1'b1, ALU_SUB};
      FN_AND:  r = {1'b1, ALU_AND};
      FN_OR:   r = {1'b1, ALU_OR};
      FN_SLT:  r = {1'b1, ALU_SLT};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Control word for a state; fn selects the ALU operation in EXEC.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] fn);
    ctrl_t c;
    logic [OP_W:0] fd;
    c  = '0;
    fd = funct_decode(fn);
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = fd[OP_W-1:0];
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 2'b01;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t          st_q;
  state_t          nxt;
  ctrl_t           ctl;
  logic [WC_W-1:0] wait_cnt;
  logic            wait_st;
  logic            timeout_hit;
  logic            illegal_c;
  logic [OP_W:0]   fdec;

  assign fdec = funct_decode(funct);

  always_comb begin
    nxt         = st_q;
    illegal_c   = 1'b0;
    wait_st     = (st_q == S_FETCH) || (st_q == S_MEMRD) || (st_q == S_MEMWR);
    timeout_hit = (TIMEOUT != 0) && wait_st && !mem_ready && (wait_cnt == TO_LAST);
    case (st_q)
      S_IDLE:  nxt = S_FETCH;
      S_FETCH: begin
        if (timeout_hit)    nxt = S_FETCH;
        else if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      nxt = S_EXEC;
          OP_LW, OP_SW:  nxt = S_MEMADR;
          OP_BEQ:        nxt = S_BRANCH;
          OP_J:          nxt = S_JUMP;
          OP_ADDI:       nxt = S_ADDIEX;
          default: begin
            illegal_c = 1'b1;
            nxt       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (timeout_hit)    nxt = S_FETCH;
        else if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWR: begin
        if (timeout_hit || mem_ready) nxt = S_FETCH;
      end
      S_EXEC: begin
        if (fdec[OP_W]) begin
          nxt = S_ALUWB;
        end else begin
          illegal_c = 1'b1;
          nxt       = S_FETCH;
        end
      end
      S_ADDIEX: nxt = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: nxt = S_FETCH;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q     <= S_IDLE;
      ctl      <= '0;
      wait_cnt <= '0;
`ifdef MIPS_CTRL_PERF_EN
      cycle_cnt <= '0;
      instr_cnt <= '0;
`endif
    end else begin
      st_q <= nxt;
      ctl  <= decode_ctrl(nxt, funct);
      // Any cycle that is not an ongoing stall leaves the counter at zero,
      // so every entry into a wait state starts a fresh count.
      if (wait_st && !mem_ready && !timeout_hit) wait_cnt <= wait_cnt + WC_W'(1);
      else                                       wait_cnt <= '0;
`ifdef MIPS_CTRL_PERF_EN
      if (st_q != S_IDLE) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (nxt == S_FETCH && st_q != S_FETCH && st_q != S_IDLE &&
          !illegal_c && !timeout_hit)
        instr_cnt <= instr_cnt + CNT_W'(1);
`endif
    end
  end

  // A timed-out access releases the bus in the very cycle bus_err fires.
  assign mem_req    = ctl.mem_req & ~timeout_hit;
  assign mem_we     = ctl.mem_we & ~timeout_hit;
  assign iord       = ctl.iord;
  // ir_write is set only in FETCH, so it also marks the pc_write that must
  // wait for the instruction fetch to complete.
  assign ir_write   = ctl.ir_write & mem_ready;
  assign pc_en      = (ctl.pc_write & (~ctl.ir_write | mem_ready)) |
                      (ctl.pc_write_cond & zero);
  assign pc_src     = ctl.pc_src;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign alu_op     = ctl.alu_op;
  assign reg_write  = ctl.reg_write;
  assign reg_dst    = ctl.reg_dst;
  assign mem_to_reg = ctl.mem_to_reg;
  assign illegal    = illegal_c;
  assign bus_err    = timeout_hit;
  assign state      = st_q;

endmodule
